// File: rtl/finish_seq_ctrl.sv
// Race finish overlay sequencer: slides the finish box in, holds it, then waits for an ack.
// Optional macro FINISH_BLINK_EN enables text blinking during HOLD.
module finish_seq_ctrl #(
  parameter int unsigned SLIDE_START  = 320,
  parameter int unsigned SLIDE_STEP   = 8,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned BLINK_PERIOD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       finish_evt,
  input  logic [1:0] winner_in,
  input  logic       ack,
  output logic       box_en,
  output logic [9:0] y_offset,
  output logic       text_en,
  output logic [1:0] winner_id,
  output logic       busy,
  output logic       done
);

  if (SLIDE_START > 1023 || SLIDE_STEP == 0 || HOLD_FRAMES == 0 || HOLD_FRAMES > 256 ||
      BLINK_PERIOD == 0 || BLINK_PERIOD > 256) begin : g_bad_param
    $error("finish_seq_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SLIDE, HOLD, WAIT_ACK} state_t;

  localparam logic [9:0] START     = 10'(SLIDE_START);
  localparam logic [9:0] STEP      = 10'(SLIDE_STEP);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t     state, state_nxt;
  logic [9:0] y_nxt;
  logic [7:0] frame_cnt, frame_nxt;
  logic [1:0] winner_nxt;
  logic       done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      y_offset  <= '0;
      frame_cnt <= '0;
      winner_id <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      y_offset  <= y_nxt;
      frame_cnt <= frame_nxt;
      winner_id <= winner_nxt;
      done      <= done_nxt;
    end
  end

  // A finish_evt coinciding with the done pulse is dropped; acceptance resumes next cycle.
  always_comb begin
    state_nxt  = state;
    y_nxt      = y_offset;
    frame_nxt  = frame_cnt;
    winner_nxt = winner_id;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (finish_evt && !done) begin
          state_nxt  = SLIDE;
          winner_nxt = winner_in;
          y_nxt      = START;
        end
      end
      SLIDE: begin
        if (frame_tick) begin
          if (y_offset > STEP) begin
            y_nxt = y_offset - STEP;
          end else begin
            y_nxt     = '0;
            state_nxt = HOLD;
            frame_nxt = '0;
          end
        end
      end
      HOLD: begin
        if (frame_tick) begin
          frame_nxt = frame_cnt + 8'd1;
          if (frame_cnt == HOLD_LAST) state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          state_nxt = IDLE;
          y_nxt     = '0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign box_en = busy;

`ifdef FINISH_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);

  logic [7:0] blink_cnt, blink_nxt;
  logic       text_q, text_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      text_q    <= 1'b0;
    end else begin
      blink_cnt <= blink_nxt;
      text_q    <= text_nxt;
    end
  end

  always_comb begin
    blink_nxt = blink_cnt;
    text_nxt  = text_q;
    unique case (state)
      IDLE:     if (state_nxt == SLIDE) text_nxt = 1'b1;
      SLIDE: begin
        if (state_nxt == HOLD) begin
          text_nxt  = 1'b1;
          blink_nxt = '0;
        end
      end
      HOLD: begin
        if (state_nxt == WAIT_ACK) begin
          text_nxt = 1'b1;
        end else if (frame_tick) begin
          if (blink_cnt == BLINK_LAST) begin
            text_nxt  = ~text_q;
            blink_nxt = '0;
          end else begin
            blink_nxt = blink_cnt + 8'd1;
          end
        end
      end
      WAIT_ACK: if (state_nxt == IDLE) text_nxt = 1'b0;
      default:  text_nxt = 1'b0;
    endcase
  end

  assign text_en = text_q;
`else
  assign text_en = box_en;
`endif

endmodule
